// File: rtl/prbs_tx_if.sv
// Valid/ready byte stream of the PRBS pattern transmitter. It carries the
// clean reference byte and the possibly corrupted byte driven onto the link.
interface prbs_tx_if;
   logic       valid_o;
   logic       ready_i;
   logic [7:0] sent_data;
   logic [7:0] tx_data;

   modport master (output valid_o, sent_data, tx_data, input ready_i);
   modport slave  (input valid_o, sent_data, tx_data, output ready_i);
endinterface

// File: rtl/prbs_tx.sv
// Paced PRBS-15 (x^15+x^14+1) byte transmitter with a valid/ready handshake.
// It can flip one bit in every ERR_PERIOD-th accepted byte.
module prbs_tx #(
   parameter logic [14:0] SEED        = 15'h7FFF,
   parameter logic [31:0] BYTE_PERIOD = 32'd1,
   parameter logic [31:0] ERR_PERIOD  = 32'd0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        enable,
   input  logic        restart,
   prbs_tx_if.master   bus,
   output logic [31:0] byte_count,
   output logic [31:0] inj_count
);

   localparam logic [14:0] SEED_EFF = (SEED == 15'd0) ? 15'h7FFF : SEED;
   localparam logic [31:0] GAP_LOAD = BYTE_PERIOD - 32'd1;
   localparam logic [31:0] ERR_LAST = ERR_PERIOD - 32'd1;
   localparam logic        INJ_ON   = (ERR_PERIOD != 32'd0);
   localparam logic        PACED    = (BYTE_PERIOD > 32'd1);

   typedef enum logic [1:0] {
      IDLE,
      PRESENT,
      GAP
   } state_t;

   state_t      r_state;
   logic        r_valid;
   logic [14:0] r_lfsr;
   logic [31:0] r_gap_cnt;
   logic [31:0] r_byte_cnt;
   logic [31:0] r_inj_cnt;
   logic [31:0] r_err_cnt;
   logic [2:0]  r_err_bit;

   logic [14:0] w_lfsr_next;
   logic [7:0]  w_prbs_byte;
   logic        w_accept;
   logic        w_corrupt;
   logic [7:0]  w_err_mask;

   // Eight serial LFSR steps unrolled. The first feedback bit lands in the
   // MSB of the byte. Returns {state after 8 steps, byte}.
   function automatic logic [22:0] lfsr_step8(input logic [14:0] s);
      logic [14:0] st;
      logic [7:0]  b;
      logic        fb;
      st = s;
      b  = 8'h00;
      for (int i = 0; i < 8; i++) begin
         fb = st[14] ^ st[13];
         st = {st[13:0], fb};
         b  = {b[6:0], fb};
      end
      return {st, b};
   endfunction

   assign {w_lfsr_next, w_prbs_byte} = lfsr_step8(r_lfsr);

   assign w_accept   = r_valid && bus.ready_i;
   assign w_corrupt  = INJ_ON && (r_err_cnt == ERR_LAST);
   assign w_err_mask = w_corrupt ? (8'h01 << r_err_bit) : 8'h00;

   assign bus.valid_o   = r_valid;
   assign bus.sent_data = w_prbs_byte;
   assign bus.tx_data   = w_prbs_byte ^ w_err_mask;
   assign byte_count    = r_byte_cnt;
   assign inj_count     = r_inj_cnt;

   // NOTE: all state uses non-blocking assignments, so every branch below reads
   // the values from before this edge. The order of the statements does not matter.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= IDLE;
         r_valid    <= 1'b0;
         r_lfsr     <= SEED_EFF;
         r_gap_cnt  <= 32'd0;
         r_byte_cnt <= 32'd0;
         r_inj_cnt  <= 32'd0;
         r_err_cnt  <= 32'd0;
         r_err_bit  <= 3'd0;
      end else if (restart) begin
         r_state    <= IDLE;
         r_valid    <= 1'b0;
         r_lfsr     <= SEED_EFF;
         r_gap_cnt  <= 32'd0;
         r_byte_cnt <= 32'd0;
         r_inj_cnt  <= 32'd0;
         r_err_cnt  <= 32'd0;
         r_err_bit  <= 3'd0;
      end else begin
         if (r_lfsr == 15'd0) begin
            r_lfsr <= 15'h7FFF;
         end else if (w_accept) begin
            r_lfsr <= w_lfsr_next;
         end

         if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 32'd1;
            if (w_corrupt) begin
               r_err_cnt <= 32'd0;
               r_err_bit <= r_err_bit + 3'd1;
               r_inj_cnt <= r_inj_cnt + 32'd1;
            end else begin
               r_err_cnt <= r_err_cnt + 32'd1;
            end
         end

         case (r_state)
            IDLE: begin
               if (enable) begin
                  r_state <= PRESENT;
                  r_valid <= 1'b1;
               end
            end
            PRESENT: begin
               // A byte that is already presented stays valid until it is taken,
               // even when enable drops.
               if (w_accept) begin
                  if (!enable) begin
                     r_state <= IDLE;
                     r_valid <= 1'b0;
                  end else if (PACED) begin
                     r_state   <= GAP;
                     r_valid   <= 1'b0;
                     r_gap_cnt <= GAP_LOAD;
                  end
               end
            end
            GAP: begin
               if (!enable) begin
                  r_state   <= IDLE;
                  r_gap_cnt <= 32'd0;
               end else if (r_gap_cnt == 32'd1) begin
                  r_state   <= PRESENT;
                  r_valid   <= 1'b1;
                  r_gap_cnt <= 32'd0;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 32'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/prbs_tx.md
# prbs_tx

Pattern transmitter for the link bit-error-rate test path. Generates a paced PRBS-15 byte stream under a valid/ready handshake, and can inject single-bit errors at a programmable byte interval. `sent_data` is the clean reference for the BER meter. `tx_data` is the possibly-corrupted byte driven onto the link under test.

## Interface

**Parameters**
- `SEED`, default 15'h7FFF: LFSR load value. A value of 0 is replaced by 15'h7FFF.
- `BYTE_PERIOD`, default 32'd1: minimum cycles from one byte acceptance to the next `valid_o`. Must be ≥ 1; 1 means back-to-back.
- `ERR_PERIOD`, default 32'd0: corrupt every ERR_PERIOD-th accepted byte. 0 disables injection.

**Ports**
- `CLK`, in, 1: sole clock, rising edge.
- `RST`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: run request; level-sensitive.
- `restart`, in, 1: synchronous one-cycle pulse. Reloads SEED, clears counters, returns to IDLE.
- `ready_i`, in, 1: downstream accepts the current byte this cycle.
- `valid_o`, out, 1: byte presented.
- `sent_data`, out, 8: clean PRBS byte.
- `tx_data`, out, 8: `sent_data` XOR the injection mask.
- `byte_count`, out, 32: bytes accepted; wraps modulo 2^32.
- `inj_count`, out, 32: bits injected; wraps modulo 2^32.

## Operation

**LFSR**
- 15-bit state `s`, polynomial x^15+x^14+1.
- One step: `fb = s[14]^s[13]`, then `s <= {s[13:0], fb}`. The output bit is `fb`.
- A byte is 8 steps, MSB first: step 1 gives bit 7, step 8 gives bit 0.
- `sent_data` is combinational from `s`: the 8 bits the next 8 steps would produce.
- `s` advances by 8 steps only on acceptance (`valid_o && ready_i`).
- If `s` is ever all-zero, the next cycle loads 15'h7FFF.

**State machine: IDLE, PRESENT, GAP**
- IDLE: `valid_o = 0`. Go to PRESENT when `enable = 1`.
- PRESENT: `valid_o = 1`. `sent_data` and `tx_data` are held stable until accepted. On acceptance:
  - increment `byte_count`;
  - advance the LFSR;
  - update the injection counters.
- Next state after acceptance:
  - `enable = 0` → IDLE;
  - `BYTE_PERIOD = 1` → stay in PRESENT with the next byte;
  - otherwise → GAP, gap counter loaded with BYTE_PERIOD-1.
- GAP: `valid_o = 0`. The counter decrements each cycle; at 1 the next state is PRESENT. If `enable = 0` in GAP → IDLE immediately.
- `enable` falling in PRESENT does not withdraw `valid_o`. The current byte is held until accepted, then the block goes to IDLE. `valid_o` never drops without acceptance, except on `restart` or reset.
- The LFSR and counters persist across IDLE. Only `restart` or `RST` reload them.

**Error injection**
- `err_cnt` (32 bits) counts accepted bytes modulo ERR_PERIOD.
- `err_bit` (3 bits) selects the bit to flip.
- The presented byte is corrupted iff `ERR_PERIOD != 0` and `err_cnt == ERR_PERIOD-1`.
- When corrupted, `tx_data = sent_data ^ (8'h01 << err_bit)`. Otherwise `tx_data = sent_data`.
- On acceptance of a corrupted byte:
  - `err_cnt <= 0`;
  - `err_bit` increments, wrapping 7 → 0;
  - `inj_count` increments.
- On acceptance of a clean byte, `err_cnt` increments.

**restart**
- Takes priority over all other events in the same cycle.
- Loads `s = SEED` (or 15'h7FFF if SEED is 0).
- Clears `byte_count`, `inj_count`, `err_cnt`, `err_bit` and the gap counter.
- Next state is IDLE. A simultaneous `ready_i` is ignored: no count, no advance.

## Timing

**Reset values**
- `valid_o = 0`, state IDLE.
- `s = SEED`, so `sent_data = tx_data = 8'h00` with the default seed.
- `byte_count = 0`, `inj_count = 0`, `err_cnt = 0`, `err_bit = 0`.
- Reset asserted mid-byte drops `valid_o` asynchronously. No acceptance is counted.

**Latency and throughput**
- `valid_o` is registered. It rises one cycle after `enable` is sampled high in IDLE.
- Acceptance happens at the rising edge where `valid_o && ready_i`. The new byte is visible in the following cycle.
- With `BYTE_PERIOD = N > 1` and `ready_i` tied high: `valid_o` is high 1 cycle, low N-1 cycles, so one byte per N cycles.
- With `BYTE_PERIOD = 1` and `ready_i` tied high: one byte per cycle.
- Stalls (`ready_i = 0`) stretch PRESENT. The GAP length is unaffected.

## Test plan

1. **Default sequence.** Reset with defaults, `enable = 1`, `ready_i = 1`. Required:
   - `valid_o` is high continuously from cycle 1;
   - bytes are 0x00, 0x02, …;
   - `tx_data == sent_data` throughout;
   - `byte_count` reads 2 after two acceptances.
2. **Pacing.** `BYTE_PERIOD = 4`, `ready_i = 1`, run 40 cycles. Required: `valid_o` follows the pattern 1,0,0,0 repeating, giving 10 bytes and `byte_count = 10`.
3. **Backpressure.** Hold `ready_i = 0` for 5 cycles during PRESENT. Required:
   - `valid_o`, `sent_data` and `tx_data` are stable for all 5 cycles;
   - the byte is accepted on the first cycle `ready_i = 1`;
   - no byte is skipped compared with a free-running reference model.
4. **Injection.** `ERR_PERIOD = 4`, 32 bytes. Required:
   - bytes 3, 7, 11, … (0-based) differ from `sent_data` in bits 0, 1, 2, …;
   - after 32 bytes, `inj_count = 8` and `err_bit` has wrapped to 0;
   - looped back into the BER meter, the accumulated error count is 8.
5. **enable drop.** Deassert `enable` in PRESENT with `ready_i = 0` for 3 cycles, then `ready_i = 1`. Required: the byte stays valid until accepted, `valid_o` is 0 from the next cycle, and the state is IDLE. Re-enabling continues with the next PRBS byte rather than restarting from seed.
6. **restart and reset.** Pulse `restart` together with `ready_i = 1` mid-stream, then re-enable. Required:
   - `byte_count = 0` and the restarted stream begins 0x00, 0x02;
   - asserting `RST` while `valid_o = 1` forces `valid_o = 0` before the next clock edge.
